// File: rtl/exe_issue_sched_if.sv
// Issue-queue <-> scheduler handshake: request, kill, per-unit active-low grants, stall.
interface exe_issue_sched_if;
  logic       issue_e_;
  logic [2:0] issue_unit;
  logic       issue_miss;
  logic       issue_alu_;
  logic       issue_div_;
  logic       issue_fpu_;
  logic       issue_fdiv_;
  logic       issue_csr_;
  logic       issue_mem_;
  logic       issue_invalid_;
  logic       issue_stall;

  modport master (
    output issue_e_, issue_unit, issue_miss,
    input  issue_alu_, issue_div_, issue_fpu_, issue_fdiv_, issue_csr_, issue_mem_,
    input  issue_invalid_, issue_stall
  );

  modport slave (
    input  issue_e_, issue_unit, issue_miss,
    output issue_alu_, issue_div_, issue_fpu_, issue_fdiv_, issue_csr_, issue_mem_,
    output issue_invalid_, issue_stall
  );
endinterface

// File: rtl/exe_issue_sched.sv
// Issue scheduler: decodes the target unit, grants only when the unit can accept,
// and tracks DIV/FDIV/CSR occupancy plus MEM in-flight credits.
module exe_issue_sched #(
  parameter  int MEM_OUTSTANDING = 4,
  localparam int MEM_CW          = $clog2(MEM_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  exe_issue_sched_if.slave    iss,
  input  logic                div_done_,
  input  logic                fdiv_done_,
  input  logic                csr_done_,
  input  logic                mem_done_,
  output logic [3:0]          busy_vec,
  output logic [MEM_CW-1:0]   mem_cnt,
  output logic                sched_err
);

  typedef enum logic [2:0] {
    U_ALU  = 3'd0,
    U_DIV  = 3'd1,
    U_FPU  = 3'd2,
    U_FDIV = 3'd3,
    U_CSR  = 3'd4,
    U_MEM  = 3'd5
  } exe_unit_t;

  logic       div_busy, fdiv_busy, csr_busy;
  logic       mem_full, mem_empty;
  logic       req;
  logic [5:0] gnt;
  logic       invalid, stall;
  logic       mem_inc, mem_dec;
  logic       done_err;

  assign req       = !iss.issue_e_ && !iss.issue_miss;
  assign mem_full  = (mem_cnt == MEM_CW'(MEM_OUTSTANDING));
  assign mem_empty = (mem_cnt == '0);

  // Availability looks only at registered state so done pulses never reach grants
  // in the same cycle.
  always_comb begin
    gnt     = '0;
    invalid = 1'b0;
    stall   = 1'b0;
    if (reset) begin
      stall = 1'b1;
    end else if (req) begin
      unique case (iss.issue_unit)
        U_ALU:   if (!csr_busy) gnt[U_ALU] = 1'b1; else stall = 1'b1;
        U_FPU:   if (!csr_busy) gnt[U_FPU] = 1'b1; else stall = 1'b1;
        U_DIV:   if (!csr_busy && !div_busy) gnt[U_DIV] = 1'b1; else stall = 1'b1;
        U_FDIV:  if (!csr_busy && !fdiv_busy) gnt[U_FDIV] = 1'b1; else stall = 1'b1;
        U_MEM:   if (!csr_busy && !mem_full) gnt[U_MEM] = 1'b1; else stall = 1'b1;
        U_CSR:   if (!csr_busy && !div_busy && !fdiv_busy && mem_empty) gnt[U_CSR] = 1'b1;
                 else stall = 1'b1;
        default: invalid = 1'b1;
      endcase
    end
  end

  assign iss.issue_alu_     = ~gnt[U_ALU];
  assign iss.issue_div_     = ~gnt[U_DIV];
  assign iss.issue_fpu_     = ~gnt[U_FPU];
  assign iss.issue_fdiv_    = ~gnt[U_FDIV];
  assign iss.issue_csr_     = ~gnt[U_CSR];
  assign iss.issue_mem_     = ~gnt[U_MEM];
  assign iss.issue_invalid_ = ~invalid;
  assign iss.issue_stall    = stall;

  assign mem_inc = gnt[U_MEM];
  assign mem_dec = !mem_done_ && !mem_empty;

  // A grant is only possible on an idle unit, so a coinciding done is always an
  // idle-unit done and lands here too.
  assign done_err = (!div_done_  && !div_busy)  ||
                    (!fdiv_done_ && !fdiv_busy) ||
                    (!csr_done_  && !csr_busy)  ||
                    (!mem_done_  && mem_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_busy  <= 1'b0;
      fdiv_busy <= 1'b0;
      csr_busy  <= 1'b0;
      mem_cnt   <= '0;
      sched_err <= 1'b0;
    end else begin
      if (gnt[U_DIV])       div_busy  <= 1'b1;
      else if (!div_done_)  div_busy  <= 1'b0;
      if (gnt[U_FDIV])      fdiv_busy <= 1'b1;
      else if (!fdiv_done_) fdiv_busy <= 1'b0;
      if (gnt[U_CSR])       csr_busy  <= 1'b1;
      else if (!csr_done_)  csr_busy  <= 1'b0;
      if (mem_inc && !mem_dec)      mem_cnt <= mem_cnt + MEM_CW'(1);
      else if (!mem_inc && mem_dec) mem_cnt <= mem_cnt - MEM_CW'(1);
      if (done_err) sched_err <= 1'b1;
    end
  end

  assign busy_vec = {csr_busy, mem_full, fdiv_busy, div_busy};

endmodule

// File: tb/tb_exe_issue_sched.sv
// Directed bench for exe_issue_sched: per-cycle comparison against an occupancy model
// plus literal expectations for the key scenarios.
module tb_exe_issue_sched;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          div_done_, fdiv_done_, csr_done_, mem_done_;
  logic [3:0]    busy_vec;
  logic [CW-1:0] mem_cnt;
  logic          sched_err;

  exe_issue_sched_if iss();

  exe_issue_sched #(.MEM_OUTSTANDING(MO)) dut (
    .clk        (clk),
    .reset      (reset),
    .iss        (iss),
    .div_done_  (div_done_),
    .fdiv_done_ (fdiv_done_),
    .csr_done_  (csr_done_),
    .mem_done_  (mem_done_),
    .busy_vec   (busy_vec),
    .mem_cnt    (mem_cnt),
    .sched_err  (sched_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Model: which units are occupied and how many MEM ops are outstanding.
  bit m_div = 0, m_fdiv = 0, m_csr = 0, m_err = 0;
  int m_mem = 0;

  function automatic bit unit_free(input int u);
    if (m_csr) return 1'b0;
    case (u)
      1:       return !m_div;
      3:       return !m_fdiv;
      4:       return !m_div && !m_fdiv && (m_mem == 0);
      5:       return m_mem < MO;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit ok;
    int u;
    u  = int'(iss.issue_unit);
    ok = !iss.issue_e_ && !iss.issue_miss && (u < 6) && unit_free(u);
    if (reset) begin
      m_div <= 0; m_fdiv <= 0; m_csr <= 0; m_mem <= 0; m_err <= 0;
    end else begin
      m_div  <= (ok && u == 1) ? 1'b1 : (div_done_  ? m_div  : 1'b0);
      m_fdiv <= (ok && u == 3) ? 1'b1 : (fdiv_done_ ? m_fdiv : 1'b0);
      m_csr  <= (ok && u == 4) ? 1'b1 : (csr_done_  ? m_csr  : 1'b0);
      m_mem  <= m_mem + ((ok && u == 5) ? 1 : 0) - ((!mem_done_ && m_mem > 0) ? 1 : 0);
      if ((!div_done_ && !m_div) || (!fdiv_done_ && !m_fdiv) ||
          (!csr_done_ && !m_csr) || (!mem_done_ && m_mem == 0))
        m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic [5:0] eg;
    logic       ei, es;
    int         u;
    if (chk_en) begin
      eg = '1; ei = 1'b1; es = 1'b0;
      u  = int'(iss.issue_unit);
      if (reset) es = 1'b1;
      else if (!iss.issue_e_ && !iss.issue_miss) begin
        if (u >= 6) ei = 1'b0;
        else if (unit_free(u)) eg[u] = 1'b0;
        else es = 1'b1;
      end
      chk("grants", {iss.issue_mem_, iss.issue_csr_, iss.issue_fdiv_, iss.issue_fpu_,
                     iss.issue_div_, iss.issue_alu_}, eg);
      chk("invalid", iss.issue_invalid_, ei);
      chk("stall", iss.issue_stall, es);
      chk("busy_vec", busy_vec, {m_csr, m_mem == MO, m_fdiv, m_div});
      chk("mem_cnt", mem_cnt, m_mem);
      chk("sched_err", sched_err, m_err);
    end
  end

  task automatic idle();
    iss.issue_e_ = 1'b1; iss.issue_unit = 3'd0; iss.issue_miss = 1'b0;
    div_done_ = 1'b1; fdiv_done_ = 1'b1; csr_done_ = 1'b1; mem_done_ = 1'b1;
  endtask

  task automatic rq(input logic [2:0] u);
    idle();
    iss.issue_e_ = 1'b0; iss.issue_unit = u;
  endtask

  task automatic fin();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    rq(3'd0);
    fin();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_stall", iss.issue_stall, 1'b1);
    chk("rst_alu", iss.issue_alu_, 1'b1);
    fin();
    reset = 1'b0;

    // 1: ALU back-to-back
    for (int i = 0; i < 3; i++) begin
      rq(3'd0); @(negedge clk);
      chk("t1_alu", iss.issue_alu_, 1'b0);
      chk("t1_busy", busy_vec, 4'b0000);
      fin();
    end

    // 2: DIV occupancy
    rq(3'd1); @(negedge clk); chk("t2_div_g0", iss.issue_div_, 1'b0); fin();
    rq(3'd1); @(negedge clk); chk("t2_busy", busy_vec[0], 1'b1);
    chk("t2_stall1", iss.issue_stall, 1'b1); fin();
    rq(3'd1); fin();
    rq(3'd1); div_done_ = 1'b0; @(negedge clk); chk("t2_stall3", iss.issue_stall, 1'b1); fin();
    rq(3'd1); @(negedge clk); chk("t2_div_g4", iss.issue_div_, 1'b0); fin();
    idle(); div_done_ = 1'b0; fin();
    idle(); @(negedge clk); chk("t2_free", busy_vec, 4'b0000); fin();

    // FDIV independent of DIV
    rq(3'd3); fin();
    rq(3'd3); @(negedge clk); chk("fdiv_stall", iss.issue_stall, 1'b1); fin();
    rq(3'd1); @(negedge clk); chk("div_beside_fdiv", iss.issue_div_, 1'b0); fin();
    idle(); div_done_ = 1'b0; fdiv_done_ = 1'b0; fin();

    // 3: MEM credits
    for (int i = 0; i < 4; i++) begin rq(3'd5); fin(); end
    rq(3'd5); mem_done_ = 1'b0; @(negedge clk);
    chk("t3_cnt4", mem_cnt, 4); chk("t3_stall", iss.issue_stall, 1'b1); fin();
    rq(3'd5); @(negedge clk); chk("t3_cnt3", mem_cnt, 3); chk("t3_g5", iss.issue_mem_, 1'b0); fin();
    idle(); @(negedge clk); chk("t3_full", busy_vec, 4'b0100); fin();
    for (int i = 0; i < 4; i++) begin idle(); mem_done_ = 1'b0; fin(); end
    idle(); @(negedge clk); chk("t3_drained", mem_cnt, 0); fin();

    // 4: CSR drain and serialization
    rq(3'd5); fin();
    rq(3'd4); @(negedge clk); chk("t4_csr_wait", iss.issue_stall, 1'b1); fin();
    rq(3'd4); mem_done_ = 1'b0; @(negedge clk); chk("t4_csr_wait2", iss.issue_stall, 1'b1); fin();
    rq(3'd4); @(negedge clk); chk("t4_csr_g", iss.issue_csr_, 1'b0); fin();
    rq(3'd0); @(negedge clk); chk("t4_alu_blk", iss.issue_stall, 1'b1);
    chk("t4_csr_busy", busy_vec[3], 1'b1); fin();
    rq(3'd0); csr_done_ = 1'b0; @(negedge clk); chk("t4_alu_blk2", iss.issue_stall, 1'b1); fin();
    rq(3'd2); @(negedge clk); chk("t4_fpu_g", iss.issue_fpu_, 1'b0); fin();

    // 5: invalid codes and kill
    rq(3'd6); @(negedge clk); chk("t5_inv6", iss.issue_invalid_, 1'b0);
    chk("t5_inv6_st", iss.issue_stall, 1'b0); fin();
    rq(3'd7); @(negedge clk); chk("t5_inv7", iss.issue_invalid_, 1'b0); fin();
    rq(3'd1); iss.issue_miss = 1'b1; @(negedge clk);
    chk("t5_miss_g", iss.issue_div_, 1'b1); chk("t5_miss_st", iss.issue_stall, 1'b0); fin();
    idle(); @(negedge clk); chk("t5_miss_busy", busy_vec, 4'b0000); fin();

    // 6: spurious MEM done, sticky error
    idle(); mem_done_ = 1'b0; fin();
    idle(); @(negedge clk); chk("t6_err", sched_err, 1'b1); chk("t6_cnt", mem_cnt, 0); fin();
    rq(3'd0); fin();
    idle(); @(negedge clk); chk("t6_sticky", sched_err, 1'b1); fin();
    reset = 1'b1; rq(3'd5); fin();
    reset = 1'b0; idle(); @(negedge clk); chk("t6_cleared", sched_err, 1'b0); fin();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/exe_issue_sched.md
Name: exe_issue_sched

Overview:
Issue scheduler between the issue queue and the execution units; it decodes the unit selector like the existing issue-select logic, and additionally tracks occupancy of the multi-cycle and shared units.
- Grants an issue only when the target unit can accept it; otherwise it asserts a stall back to the issue queue.
- Tracks one non-pipelined DIV, one non-pipelined FDIV, a credit-limited MEM port and a fully serializing CSR unit.

Parameters:
MEM_OUTSTANDING, 4, maximum in-flight MEM ops (1..15)
MEM_CW, $clog2(MEM_OUTSTANDING+1), width of the MEM in-flight counter (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous active-high reset
issue_e_  in  1  active-low request valid from the issue queue
issue_unit  in  3  ExeUnit_t target (ALU=0, DIV=1, FPU=2, FDIV=3, CSR=4, MEM=5; 6,7 invalid)
issue_miss  in  1  kill: cancels this cycle's request (no grant, no stall, no state change)
div_done_  in  1  active-low DIV completion pulse
fdiv_done_  in  1  active-low FDIV completion pulse
csr_done_  in  1  active-low CSR completion pulse
mem_done_  in  1  active-low MEM completion, returns one credit
issue_alu_, issue_div_, issue_fpu_, issue_fdiv_, issue_csr_, issue_mem_  out  1 each  active-low grant to the unit
issue_invalid_  out  1  active-low: request carried an invalid unit code
issue_stall  out  1  active-high: valid request not granted this cycle, hold it
busy_vec  out  4  {csr_busy, mem_full, fdiv_busy, div_busy}, registered-state view
mem_cnt  out  MEM_CW  MEM in-flight count
sched_err  out  1  sticky: completion received for an idle unit

Behaviour:
- Reset (reset=1 at an edge): div_busy, fdiv_busy, csr_busy, mem_cnt, sched_err all cleared to 0.
  - While reset is high: all grants and issue_invalid_ are 1 and issue_stall=1, regardless of inputs.
- req = !issue_e_ && !issue_miss. Grants and stall are combinational from req, issue_unit and registered state only.
  - Done inputs never feed grants in the same cycle; a unit freed by a done can be granted no earlier than the next cycle.
- Availability:
  - ALU, FPU: always available unless csr_busy.
  - DIV: !div_busy && !csr_busy.
  - FDIV: !fdiv_busy && !csr_busy.
  - MEM: mem_cnt < MEM_OUTSTANDING && !csr_busy.
  - CSR: !div_busy && !fdiv_busy && mem_cnt==0 && !csr_busy. CSR waits for full drain and blocks everything while busy.
- Outcome when req=1:
  - Available unit: its grant goes low for exactly that cycle and issue_stall=0.
  - Unavailable unit: no grant and issue_stall=1.
  - Invalid code (6,7): issue_invalid_=0, issue_stall=0, no state change.
- When req=0: all grants and issue_invalid_ are 1 and issue_stall=0.
- State updates at the edge:
  - div_busy: set on DIV grant; cleared when div_done_=0. A grant and a done cannot coincide legally; if they do, set wins and sched_err is set.
  - fdiv_busy, csr_busy: same rule with their own grant and done.
  - mem_cnt: +1 on MEM grant, -1 on mem_done_=0; both in the same cycle leave it unchanged. mem_done_ at mem_cnt==0 leaves it at 0 and sets sched_err.
  - Any done for an idle unit sets sched_err. sched_err clears only on reset.
- issue_miss does not cancel in-flight units; busy state persists until the corresponding done.
- Reset mid-operation: all busy state is dropped. Done pulses arriving after reset for pre-reset ops set sched_err; the bench must not drive them.
- busy_vec[2] = (mem_cnt == MEM_OUTSTANDING).

Test Plan:
1. Reset, then ALU req every cycle for 3 cycles -> issue_alu_=0 each cycle; stall=0; busy_vec=0000.
2. DIV req at cycle 0 -> issue_div_=0; busy_vec[0]=1 at cycle 1. DIV req at cycles 1-3 -> stall=1. div_done_=0 at cycle 3 -> DIV req granted at cycle 4.
3. MEM req 5 consecutive cycles (MEM_OUTSTANDING=4) -> first 4 granted, mem_cnt=4, 5th stalls. mem_done_=0 together with the 5th req in cycle 4 -> mem_cnt stays 4 and stall=1 that cycle; grant in cycle 5.
4. MEM in flight (mem_cnt=1) then CSR req -> stall until the cycle after mem_done_. CSR granted; while csr_busy, an ALU req stalls. After csr_done_, ALU is granted the next cycle.
5. issue_unit=6 with req -> issue_invalid_=0, stall=0. DIV req with issue_miss=1 -> no grant, no stall, div_busy stays 0.
6. mem_done_=0 at mem_cnt=0 -> sched_err=1 the next cycle and stays 1 until reset; mem_cnt stays 0.
